// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: instruction-memory window, NOP encoding and
// the fetch-entry record carried from fetch through the ID pipeline register.
package mips_pkg;

  localparam logic [31:0] IM_BASE_DEF = 32'h0000_3000;
  localparam logic [31:0] IM_LAST_DEF = 32'h0000_6FFC;
  localparam logic [31:0] NOP         = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        adel;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_addr_check.sv
// Fetch address error (AdEL) detect: misaligned or outside the instruction window.
// Purely combinational, zero latency; no handshake.
// Backpressure: not applicable.
module fetch_addr_check
  import mips_pkg::*;
#(
  parameter logic [31:0] IM_BASE = IM_BASE_DEF,
  parameter logic [31:0] IM_LAST = IM_LAST_DEF
) (
  input  logic [31:0] pc,
  output logic        adel
);

  assign adel = (pc[1:0] != 2'b00) | (pc < IM_BASE) | (pc > IM_LAST);

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch queue: buffers {pc, instr, adel} between fetch and decode.
// Latency: one edge from enqueue to id_*; no bypass. Stalls fetch via pc_en when full;
// flush/reset drop all entries. id_* are held while id_valid & ~id_ready.
module fetch_queue
  import mips_pkg::*;
#(
  parameter int          DEPTH   = 4,
  parameter logic [31:0] IM_BASE = IM_BASE_DEF,
  parameter logic [31:0] IM_LAST = IM_LAST_DEF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       if_valid,
  input  logic [31:0]                if_pc,
  input  logic [31:0]                if_instr,
  input  logic                       flush,
  output logic                       pc_en,
  output logic                       id_valid,
  input  logic                       id_ready,
  output logic [31:0]                id_pc,
  output logic [31:0]                id_instr,
  output logic                       id_exc_adel,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  fetch_entry_t       mem [DEPTH];
  fetch_entry_t       new_entry;
  fetch_entry_t       head;
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic               full;
  logic               empty;
  logic               enq;
  logic               deq;
  logic               adel;

  fetch_addr_check #(
    .IM_BASE (IM_BASE),
    .IM_LAST (IM_LAST)
  ) u_addr_check (
    .pc   (if_pc),
    .adel (adel)
  );

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);

  // full uses the pre-dequeue count, so a full queue never accepts even while draining
  assign enq = if_valid & ~full & ~flush;
  assign deq = ~empty & id_ready & ~flush;

  assign new_entry.pc    = if_pc;
  assign new_entry.instr = adel ? NOP : if_instr;
  assign new_entry.adel  = adel;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + PTR_W'(1);
      if (deq) rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(enq) - CNT_W'(deq);
    end
  end

  // Storage needs no reset: stale slots are never visible because outputs are gated by empty.
  always_ff @(posedge clk) begin
    if (!reset && enq) mem[wr_ptr] <= new_entry;
  end

  assign head        = mem[rd_ptr];
  assign id_valid    = ~empty;
  assign id_pc       = empty ? 32'h0 : head.pc;
  assign id_instr    = empty ? 32'h0 : head.instr;
  assign id_exc_adel = empty ? 1'b0  : head.adel;

  assign pc_en = flush | ~full;

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction fetch queue between the fetch stage (PC register + instruction memory) and decode. Buffers up to DEPTH fetched {PC, instruction} pairs and presents them to decode with a valid/ready handshake. Drives the PC register's enable to stall fetch when the queue is full, and discards all contents on a branch/jump/exception redirect. Tags fetch-address errors (AdEL) per entry so the exception travels down the pipeline with the instruction.

## Interface
- DEPTH, 4: entry count; power of two, ≥2
- IM_BASE, 32'h00003000: first legal instruction address
- IM_LAST, 32'h00006FFC: last legal instruction address
- clk  in  1  system clock, all state updates on posedge
- reset  in  1  synchronous, active-high; one clock; reset is synchronous and active-high
- if_valid  in  1  fetch result present this cycle
- if_pc  in  32  address of fetched word (current PC register value)
- if_instr  in  32  word read from instruction memory
- flush  in  1  redirect: discard queue and this cycle's fetch
- pc_en  out  1  enable to PC register (1 = PC loads NPC)
- id_valid  out  1  head entry valid
- id_ready  in  1  decode accepts head entry
- id_pc  out  32  head entry PC
- id_instr  out  32  head entry instruction
- id_exc_adel  out  1  head entry carries fetch address error
- count  out  $clog2(DEPTH+1)  current occupancy

## Operation
- State: DEPTH×{pc[31:0], instr[31:0], adel} storage, wr_ptr/rd_ptr ($clog2(DEPTH) bits, wrap modulo DEPTH), count.
- full = (count == DEPTH); empty = (count == 0).
- enq = if_valid & ~full & ~flush; deq = id_valid & id_ready & ~flush.
- full is evaluated on the pre-dequeue count: no enqueue when full, even if dequeue happens the same cycle.
- enq & deq same cycle: both pointers advance, count unchanged.
- count next = count + enq − deq; never exceeds DEPTH or goes below 0.
- flush: next cycle count=0, wr_ptr=rd_ptr=0; concurrent enq/deq ignored; id_ready ignored.
- AdEL: adel = (if_pc[1:0] ≠ 0) | (if_pc < IM_BASE) | (if_pc > IM_LAST). Enqueued entry stores adel; when adel=1, instr stored as 32'h00000000 (nop), pc stored unchanged.
- Outputs: id_valid = ~empty. When empty: id_pc, id_instr, id_exc_adel = 0. Otherwise they show the rd_ptr entry.
- pc_en = flush | ~full. During flush the PC loads the redirect target.

## Timing
- Reset values: count=0, pointers=0, id_valid=0, id_pc=0, id_instr=0, id_exc_adel=0, pc_en=1.
- Latency: an entry enqueued at edge N is visible on id_* after edge N (cycle N+1). No combinational bypass from if_* to id_*.
- id_* are driven from registered storage and pointers only; no path from id_ready to id_*.
- pc_en and id_valid have no combinational dependence on if_* or id_ready.
- pc_en depends combinationally on flush and count.
- Handshake: id_* are held stable while id_valid=1 and id_ready=0.
- reset mid-operation: all entries dropped at that edge, same as flush; reset has priority over flush.

## Structure
- Shared package mips_pkg holds:
  - IM_BASE and IM_LAST defaults
  - NOP = 32'h00000000
  - a fetch-entry struct {pc, instr, adel} reused by the ID pipeline register
- One sub-module, fetch_addr_check: combinational AdEL detect, if_pc → adel. Reused later by the data-side address checker pattern.
- Storage, pointers and count stay in fetch_queue.

## Test plan
- Reset: assert reset 1 cycle → count=0, id_valid=0, id_pc=0, pc_en=1.
- Fill/drain: if_valid=1, if_pc = 0x3000, 0x3004, 0x3008, 0x300C, 0x3010, id_ready=0.
  - After 4 edges: count=4, pc_en=0; 0x3010 not stored.
  - Then id_ready=1: id_pc sequence 0x3000..0x300C, then id_valid=0.
- Simultaneous enq/deq at count=2, pointers wrapped past DEPTH−1 → count stays 2, FIFO order preserved across wrap.
- Full + deq same cycle: count=4, if_valid=1, id_ready=1 → count=3 next cycle, incoming word dropped, pc_en=1 next cycle.
- Flush with count=3, if_valid=1, id_ready=1 → next cycle count=0, id_valid=0, pc_en=1 during flush cycle.
- AdEL: enqueue if_pc=0x3002, if_instr=0x24010001 → id_exc_adel=1, id_instr=0, id_pc=0x3002. Repeat with if_pc=0x2FFC and 0x7000 → adel=1; if_pc=0x6FFC → adel=0.
